// File: rtl/err_stat_mon_pkg.sv
// Shared types and default constants for the approximate-adder error statistics monitor.
package err_stat_mon_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ER_THRESH1 = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [63:0] acc_t;

endpackage

// File: rtl/err_stat_mon_calc.sv
// Combinational error evaluation of one sample: exact sum, signed/absolute error,
// exact flag and upper-part correctness flag.
module err_calc
  import err_stat_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ER_THRESH1 = DEF_ER_THRESH1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_appr,
  output logic [WIDTH-1:0] exact,
  output acc_t             err_ext,
  output logic [WIDTH:0]   abs_err,
  output logic             is_exact,
  output logic             hi_ok
);

  localparam int HI_W = WIDTH - ER_THRESH1;

  logic signed [WIDTH:0] err;
  logic [HI_W-1:0]       hi_sum;

  always_comb begin
    exact    = a + b;
    // Both operands are treated as two's complement, so the difference needs one extra bit.
    err      = $signed({s_appr[WIDTH-1], s_appr}) - $signed({exact[WIDTH-1], exact});
    abs_err  = err[WIDTH] ? $unsigned(-err) : $unsigned(err);
    err_ext  = {{(63-WIDTH){err[WIDTH]}}, err};
    is_exact = (err == '0);
    hi_sum   = a[WIDTH-1:ER_THRESH1] + b[WIDTH-1:ER_THRESH1];
    hi_ok    = (s_appr[WIDTH-1:ER_THRESH1] == hi_sum);
  end

endmodule

// File: rtl/err_stat_mon.sv
// Measurement-run controller: accepts n_samples operand/sum triples and accumulates
// error statistics of an approximate adder through a two-stage pipeline.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; statistics of the last run are held
//   ST_RUN   | accepting samples until n_samples have transferred
//   ST_DRAIN | input closed, waiting for the pipeline to empty
//   ST_DONE  | one-cycle done pulse, then back to idle
module err_stat_mon
  import err_stat_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ER_THRESH1 = DEF_ER_THRESH1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_appr,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cnt,
  output logic [63:0]      err_sum,
  output logic [63:0]      abs_err_sum,
  output logic [WIDTH:0]   max_abs_err,
  output logic [31:0]      n_exact,
  output logic [31:0]      n_hi_ok
);

  state_e           state_q, state_d;
  logic [31:0]      n_q, n_d;
  logic [31:0]      acc_cnt_q, acc_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_s_q, s1_s_d;
  logic [31:0]      cnt_q, cnt_d;
  acc_t             err_sum_q, err_sum_d;
  acc_t             abs_sum_q, abs_sum_d;
  logic [WIDTH:0]   max_q, max_d;
  logic [31:0]      n_exact_q, n_exact_d;
  logic [31:0]      n_hi_ok_q, n_hi_ok_d;

  logic             xfer;
  logic [WIDTH-1:0] c_exact;
  acc_t             c_err_ext;
  logic [WIDTH:0]   c_abs_err;
  logic             c_is_exact;
  logic             c_hi_ok;

  err_calc #(
    .WIDTH      (WIDTH),
    .ER_THRESH1 (ER_THRESH1)
  ) u_err_calc (
    .a        (s1_a_q),
    .b        (s1_b_q),
    .s_appr   (s1_s_q),
    .exact    (c_exact),
    .err_ext  (c_err_ext),
    .abs_err  (c_abs_err),
    .is_exact (c_is_exact),
    .hi_ok    (c_hi_ok)
  );

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    acc_cnt_d  = acc_cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    s1_vld_d   = xfer;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_s_d     = s1_s_q;
    cnt_d      = cnt_q;
    err_sum_d  = err_sum_q;
    abs_sum_d  = abs_sum_q;
    max_d      = max_q;
    n_exact_d  = n_exact_q;
    n_hi_ok_d  = n_hi_ok_q;

    if (xfer) begin
      s1_a_d = a;
      s1_b_d = b;
      s1_s_d = s_appr;
    end

    // Stage 2: fold the registered sample into the statistics.
    if (s1_vld_q) begin
      cnt_d     = cnt_q + 32'd1;
      err_sum_d = err_sum_q + c_err_ext;
      abs_sum_d = abs_sum_q + {{(63-WIDTH){1'b0}}, c_abs_err};
      if (c_abs_err > max_q) max_d = c_abs_err;
      if (c_is_exact) n_exact_d = n_exact_q + 32'd1;
      if (c_hi_ok) n_hi_ok_d = n_hi_ok_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d       = n_samples;
          acc_cnt_d = '0;
          cnt_d     = '0;
          err_sum_d = '0;
          abs_sum_d = '0;
          max_d     = '0;
          n_exact_d = '0;
          n_hi_ok_d = '0;
          if (n_samples == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_RUN;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          acc_cnt_d = acc_cnt_q + 32'd1;
          if (acc_cnt_q + 32'd1 == n_q) begin
            in_ready_d = 1'b0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      acc_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_s_q     <= '0;
      cnt_q      <= '0;
      err_sum_q  <= '0;
      abs_sum_q  <= '0;
      max_q      <= '0;
      n_exact_q  <= '0;
      n_hi_ok_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      acc_cnt_q  <= acc_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_s_q     <= s1_s_d;
      cnt_q      <= cnt_d;
      err_sum_q  <= err_sum_d;
      abs_sum_q  <= abs_sum_d;
      max_q      <= max_d;
      n_exact_q  <= n_exact_d;
      n_hi_ok_q  <= n_hi_ok_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt         = cnt_q;
  assign err_sum     = err_sum_q;
  assign abs_err_sum = abs_sum_q;
  assign max_abs_err = max_q;
  assign n_exact     = n_exact_q;
  assign n_hi_ok     = n_hi_ok_q;

endmodule

// File: tb/tb_err_stat_mon.sv
// Bench for err_stat_mon: per-run expected statistics are queued when a run is launched
// and compared against the DUT when its done pulse appears.
module tb_err_stat_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] n_samples;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, s_appr;
  logic        busy, done;
  logic [31:0] cnt;
  logic [63:0] err_sum, abs_err_sum;
  logic [32:0] max_abs_err;
  logic [31:0] n_exact, n_hi_ok;

  typedef struct {
    logic [31:0] cnt;
    logic [63:0] es;
    logic [63:0] as;
    logic [32:0] mx;
    logic [31:0] ne;
    logic [31:0] nh;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] sa[8], sbv[8], ss[8];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  err_stat_mon #(.WIDTH(32), .ER_THRESH1(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .s_appr      (s_appr),
    .busy        (busy),
    .done        (done),
    .cnt         (cnt),
    .err_sum     (err_sum),
    .abs_err_sum (abs_err_sum),
    .max_abs_err (max_abs_err),
    .n_exact     (n_exact),
    .n_hi_ok     (n_hi_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t        e;
    logic [31:0] ex;
    logic [23:0] h;
    longint      er, ab;
    e = '{cnt: 0, es: 0, as: 0, mx: 0, ne: 0, nh: 0};
    for (int i = 0; i < n; i++) begin
      ex = sa[i] + sbv[i];
      er = longint'($signed(ss[i])) - longint'($signed(ex));
      ab = (er < 0) ? -er : er;
      e.cnt = e.cnt + 32'd1;
      e.es  = e.es + 64'(er);
      e.as  = e.as + 64'(ab);
      if (33'(ab) > e.mx) e.mx = 33'(ab);
      if (er == 0) e.ne = e.ne + 32'd1;
      h = sa[i][31:8] + sbv[i][31:8];
      if (ss[i][31:8] == h) e.nh = e.nh + 32'd1;
    end
    return e;
  endfunction

  task automatic cmp_stats(input string tag, input exp_t e);
    chk({tag, ".cnt"}, 64'(cnt), 64'(e.cnt));
    chk({tag, ".err_sum"}, err_sum, e.es);
    chk({tag, ".abs_sum"}, abs_err_sum, e.as);
    chk({tag, ".max"}, 64'(max_abs_err), 64'(e.mx));
    chk({tag, ".n_exact"}, 64'(n_exact), 64'(e.ne));
    chk({tag, ".n_hi_ok"}, 64'(n_hi_ok), 64'(e.nh));
  endtask

  // abort_after < 0: normal run; otherwise rst is applied once that many samples transferred.
  task automatic do_run(input string tag, input int n, input bit gap, input bit restart_mid,
                        input int abort_after);
    exp_t e;
    int   idx, cyc, last_x;
    bit   got_done, rdy_seen, tog, vld;
    if (abort_after < 0) sb_q.push_back(model(n));
    @(negedge clk);
    start = 1'b1; n_samples = 32'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) chk({tag, ".busy_run"}, 64'(busy), 64'd1);
    idx = 0; cyc = 0; last_x = 0; got_done = 0; rdy_seen = 0; tog = 0;
    while (!got_done && cyc < 200) begin
      if (done) begin
        got_done = 1;
        in_valid = 1'b0;
        if (sb_q.size() == 0) chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        else begin
          e = sb_q.pop_front();
          cmp_stats(tag, e);
        end
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        if (n > 0) chk({tag, ".done_lat"}, 64'(cyc - last_x), 64'd3);
      end else begin
        if (in_ready) rdy_seen = 1;
        if (abort_after >= 0 && idx == abort_after) begin
          rst = 1'b1; in_valid = 1'b1; start = 1'b1;
          @(negedge clk);
          rst = 1'b0; in_valid = 1'b0; start = 1'b0;
          chk({tag, ".rst_rdy"}, 64'(in_ready), 64'd0);
          chk({tag, ".rst_busy"}, 64'(busy), 64'd0);
          cmp_stats({tag, ".rst"}, '{cnt: 0, es: 0, as: 0, mx: 0, ne: 0, nh: 0});
          rdy_seen = 0;
          for (int k = 0; k < 8; k++) begin
            if (done) rdy_seen = 1;
            @(negedge clk);
          end
          chk({tag, ".no_done"}, 64'(rdy_seen), 64'd0);
          return;
        end
        tog = ~tog;
        vld = (idx < n) && (!gap || tog);
        in_valid = vld;
        if (idx < n) begin
          a = sa[idx]; b = sbv[idx]; s_appr = ss[idx];
        end
        if (restart_mid && cyc == 3) begin
          start = 1'b1; n_samples = 32'd1;
        end else start = 1'b0;
        if (vld && in_ready) begin
          idx++;
          last_x = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!got_done) chk({tag, ".done_timeout"}, 64'd0, 64'd1);
    if (n == 0) chk({tag, ".rdy_never"}, 64'(rdy_seen), 64'd0);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 64'(done), 64'd0);
    chk({tag, ".hold_cnt"}, 64'(cnt), 64'(n));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; s_appr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.rdy", 64'(in_ready), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    cmp_stats("reset", '{cnt: 0, es: 0, as: 0, mx: 0, ne: 0, nh: 0});

    sa[0] = 32'd5; sbv[0] = 32'd7; ss[0] = 32'd12;
    do_run("single", 1, 0, 0, -1);

    sa[0] = 32'h100; sbv[0] = 32'h0FF; ss[0] = 32'h1FE;
    sa[1] = 32'h080; sbv[1] = 32'h080; ss[1] = 32'h000;
    do_run("pair", 2, 0, 0, -1);

    sa[0] = 32'hFFFF_FFFF; sbv[0] = 32'd1; ss[0] = 32'd0;
    do_run("wrap", 1, 0, 0, -1);

    do_run("zero", 0, 0, 0, -1);

    sa[0] = 32'd10;        sbv[0] = 32'd20;   ss[0] = 32'd30;
    sa[1] = 32'h1234;      sbv[1] = 32'h10;   ss[1] = 32'h1240;
    sa[2] = 32'hFF;        sbv[2] = 32'h01;   ss[2] = 32'hFF;
    sa[3] = 32'h7FFF_FFFF; sbv[3] = 32'd1;    ss[3] = 32'h7FFF_FFFF;
    do_run("gap", 4, 1, 1, -1);

    for (int i = 0; i < 6; i++) begin
      sa[i]  = $urandom;
      sbv[i] = $urandom;
      ss[i]  = (sa[i] + sbv[i]) ^ ((i % 2 == 0) ? 32'($urandom_range(0, 511)) : 32'd0);
    end
    do_run("rand", 6, 0, 0, -1);

    do_run("abort", 4, 0, 0, 2);

    sa[0] = 32'd5; sbv[0] = 32'd7; ss[0] = 32'd13;
    do_run("recover", 1, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
